// File: rtl/cameralink_36bit_medium_rx.sv
// Camera Link 36-bit Medium receive unpacker: X/Y/Z channel words -> 12-bit RGB + sync,
// with cross-channel sync check and optional line/frame geometry (macro CL_RX_GEOMETRY_EN).
module cameralink_36bit_medium_rx (
  input  logic        I_Pixel_clk,
  input  logic        I_Rst_n,
  input  logic [27:0] I_X_FPGA_DATA,
  input  logic [27:0] I_Y_FPGA_DATA,
  input  logic [27:0] I_Z_FPGA_DATA,
  input  logic        I_Err_Clr,
  output logic [11:0] O_Pixel_R,
  output logic [11:0] O_Pixel_G,
  output logic [11:0] O_Pixel_B,
  output logic        O_Pixel_Fval,
  output logic        O_Pixel_Lval,
  output logic        O_Pixel_Dval,
  output logic        O_Pixel_Valid,
  output logic        O_Sync_Err,
  output logic        O_Sync_Err_Sticky,
  output logic [7:0]  O_Err_Cnt,
  output logic [15:0] O_Line_Pixels,
  output logic [15:0] O_Frame_Lines,
  output logic [15:0] O_Frame_Cnt,
  output logic        O_Frame_Done
);

  typedef struct packed {
    logic [11:0] r;
    logic [11:0] g;
    logic [11:0] b;
    logic        fval;
    logic        lval;
    logic        dval;
    logic        valid;
  } pix_t;

  // Port bit scatter as wired by the Camera Link channel link
  function automatic logic [7:0] port_a(input logic [27:0] w);
    return {w[27], w[5], w[6], w[4:0]};
  endfunction
  function automatic logic [7:0] port_b(input logic [27:0] w);
    return {w[11], w[10], w[14], w[13], w[12], w[9], w[8], w[7]};
  endfunction
  function automatic logic [7:0] port_c(input logic [27:0] w);
    return {w[17], w[16], w[22], w[21], w[20], w[19], w[18], w[15]};
  endfunction
  function automatic logic [2:0] sync_of(input logic [27:0] w);
    return {w[25], w[24], w[26]};
  endfunction

  logic [27:0] s1_x_q, s1_y_q, s1_z_q, s1_x_d, s1_y_d, s1_z_d;
  logic        s1_clr_q, s1_clr_d;
  pix_t        pix_q, pix_d;
  logic        sync_err_q, sync_err_d;
  logic        sticky_q, sticky_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [7:0]  xa, xb, xc, ye, yf;
  logic [2:0]  x_sync, y_sync, z_sync;
  logic        mismatch;
  logic        unused_bits;

  // Clear travels with the data word so it lines up with that word's sync check
  always_comb begin
    s1_x_d   = I_X_FPGA_DATA;
    s1_y_d   = I_Y_FPGA_DATA;
    s1_z_d   = I_Z_FPGA_DATA;
    s1_clr_d = I_Err_Clr;
  end

  always_ff @(posedge I_Pixel_clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      s1_z_q   <= '0;
      s1_clr_q <= 1'b0;
    end else begin
      s1_x_q   <= s1_x_d;
      s1_y_q   <= s1_y_d;
      s1_z_q   <= s1_z_d;
      s1_clr_q <= s1_clr_d;
    end
  end

  always_comb begin
    xa     = port_a(s1_x_q);
    xb     = port_b(s1_x_q);
    xc     = port_c(s1_x_q);
    ye     = port_b(s1_y_q);
    yf     = port_c(s1_y_q);
    x_sync = sync_of(s1_x_q);
    y_sync = sync_of(s1_y_q);
    z_sync = sync_of(s1_z_q);

    pix_d.r     = {xb[3:0], xa};
    pix_d.b     = {xb[7:4], xc};
    pix_d.g     = {yf[3:0], ye};
    pix_d.fval  = x_sync[2];
    pix_d.lval  = x_sync[1];
    pix_d.dval  = x_sync[0];
    pix_d.valid = &x_sync;

    mismatch   = (y_sync != x_sync) || (z_sync != x_sync);
    sync_err_d = mismatch & ~s1_clr_q;
    err_cnt_d  = err_cnt_q;
    sticky_d   = sticky_q;
    if (s1_clr_q) begin
      err_cnt_d = '0;
      sticky_d  = 1'b0;
    end else if (mismatch) begin
      sticky_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge I_Pixel_clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      pix_q      <= '0;
      sync_err_q <= 1'b0;
      sticky_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      pix_q      <= pix_d;
      sync_err_q <= sync_err_d;
      sticky_q   <= sticky_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Port D, F[7:4], G/H and the spare bit are carried but never decoded
  assign unused_bits = ^{s1_x_q, s1_y_q, s1_z_q};

  assign O_Pixel_R         = pix_q.r;
  assign O_Pixel_G         = pix_q.g;
  assign O_Pixel_B         = pix_q.b;
  assign O_Pixel_Fval      = pix_q.fval;
  assign O_Pixel_Lval      = pix_q.lval;
  assign O_Pixel_Dval      = pix_q.dval;
  assign O_Pixel_Valid     = pix_q.valid;
  assign O_Sync_Err        = sync_err_q;
  assign O_Sync_Err_Sticky = sticky_q;
  assign O_Err_Cnt         = err_cnt_q;

`ifdef CL_RX_GEOMETRY_EN
  logic        fval_prev_q, lval_prev_q;
  logic [15:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic [15:0] line_pixels_q, line_pixels_d, frame_lines_q, frame_lines_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] pix_sum, line_inc;
  logic        lval_fall, line_end, frame_end;

  // A line closing on the same word FVAL drops still belongs to the frame, hence fval_prev_q
  always_comb begin
    lval_fall = lval_prev_q & ~x_sync[1];
    line_end  = lval_fall & fval_prev_q;
    frame_end = fval_prev_q & ~x_sync[2];
    pix_sum   = (!(&x_sync) || pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;
    line_inc  = (line_end && line_cnt_q != 16'hFFFF) ? line_cnt_q + 16'd1 : line_cnt_q;

    pix_cnt_d     = lval_fall ? 16'd0 : pix_sum;
    line_cnt_d    = line_inc;
    line_pixels_d = line_end ? pix_sum : line_pixels_q;
    frame_lines_d = frame_lines_q;
    frame_cnt_d   = frame_cnt_q;
    frame_done_d  = 1'b0;
    if (frame_end) begin
      frame_lines_d = line_inc;
      line_cnt_d    = '0;
      frame_cnt_d   = frame_cnt_q + 16'd1;
      frame_done_d  = 1'b1;
    end
  end

  always_ff @(posedge I_Pixel_clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      fval_prev_q   <= 1'b0;
      lval_prev_q   <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_pixels_q <= '0;
      frame_lines_q <= '0;
      frame_cnt_q   <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      fval_prev_q   <= x_sync[2];
      lval_prev_q   <= x_sync[1];
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_pixels_q <= line_pixels_d;
      frame_lines_q <= frame_lines_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign O_Line_Pixels = line_pixels_q;
  assign O_Frame_Lines = frame_lines_q;
  assign O_Frame_Cnt   = frame_cnt_q;
  assign O_Frame_Done  = frame_done_q;
`else
  assign O_Line_Pixels = '0;
  assign O_Frame_Lines = '0;
  assign O_Frame_Cnt   = '0;
  assign O_Frame_Done  = 1'b0;
`endif

endmodule

// File: tb/tb_cameralink_36bit_medium_rx.sv
// Scoreboard bench for cameralink_36bit_medium_rx: random pixels encoded from R/G/B values,
// expectations from a per-word reference model, checked by a decoupled monitor.
module tb_cameralink_36bit_medium_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] x_w = '0, y_w = '0, z_w = '0;
  logic        clr = 1'b0;
  logic [11:0] o_r, o_g, o_b;
  logic        o_f, o_l, o_d, o_v, o_serr, o_sticky, o_fd;
  logic [7:0]  o_cnt;
  logic [15:0] o_lp, o_fl, o_fc;

  cameralink_36bit_medium_rx dut (
    .I_Pixel_clk(clk), .I_Rst_n(rst_n),
    .I_X_FPGA_DATA(x_w), .I_Y_FPGA_DATA(y_w), .I_Z_FPGA_DATA(z_w), .I_Err_Clr(clr),
    .O_Pixel_R(o_r), .O_Pixel_G(o_g), .O_Pixel_B(o_b),
    .O_Pixel_Fval(o_f), .O_Pixel_Lval(o_l), .O_Pixel_Dval(o_d), .O_Pixel_Valid(o_v),
    .O_Sync_Err(o_serr), .O_Sync_Err_Sticky(o_sticky), .O_Err_Cnt(o_cnt),
    .O_Line_Pixels(o_lp), .O_Frame_Lines(o_fl), .O_Frame_Cnt(o_fc), .O_Frame_Done(o_fd));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [35:0] pix;
    logic [3:0]  sync;
    logic [9:0]  err;
    logic [48:0] geo;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0;

  int a_pos[8] = '{0, 1, 2, 3, 4, 6, 5, 27};
  int b_pos[8] = '{7, 8, 9, 12, 13, 14, 10, 11};
  int c_pos[8] = '{15, 18, 19, 20, 21, 22, 16, 17};

  // reference model state
  int m_err, m_pix, m_lines, m_lp, m_fl, m_fc;
  bit m_sticky, m_pf, m_pl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [27:0] enc(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [2:0] fld,
                                      input logic spare);
    logic [27:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[a_pos[i]] = a[i];
      w[b_pos[i]] = b[i];
      w[c_pos[i]] = c[i];
    end
    w[25] = fld[2];
    w[24] = fld[1];
    w[26] = fld[0];
    w[23] = spare;
    return w;
  endfunction

  task automatic model_reset();
    m_err = 0; m_pix = 0; m_lines = 0; m_lp = 0; m_fl = 0; m_fc = 0;
    m_sticky = 0; m_pf = 0; m_pl = 0;
  endtask

  // fld = {FVAL, LVAL, DVAL}; yx/zx flip bits of the Y/Z triplets
  task automatic send(input logic [11:0] r, input logic [11:0] g, input logic [11:0] b,
                      input logic [2:0] fld, input logic [2:0] yx, input logic [2:0] zx,
                      input logic cl);
    exp_t e;
    bit mism, serr, fd;
    logic [7:0] rf;
    @(posedge clk); #1;
    rf  = 8'($urandom);
    x_w = enc(r[7:0], {b[11:8], r[11:8]}, b[7:0], fld, 1'($urandom));
    y_w = enc(8'($urandom), g[7:0], {rf[3:0], g[11:8]}, fld ^ yx, 1'($urandom));
    z_w = enc(8'($urandom), 8'($urandom), 8'($urandom), fld ^ zx, 1'($urandom));
    clr = cl;

    mism = (yx != 0) || (zx != 0);
    serr = mism && !cl;
    if (cl) begin
      m_err = 0; m_sticky = 0;
    end else if (mism) begin
      m_sticky = 1;
      if (m_err < 255) m_err++;
    end

    fd = 0;
    if (fld == 3'b111 && m_pix < 65535) m_pix++;
    if (m_pl && !fld[1]) begin
      if (m_pf) begin
        m_lp = m_pix;
        if (m_lines < 65535) m_lines++;
      end
      m_pix = 0;
    end
    if (m_pf && !fld[2]) begin
      m_fl = m_lines;
      m_lines = 0;
      m_fc = (m_fc + 1) % 65536;
      fd = 1;
    end
    m_pf = fld[2];
    m_pl = fld[1];

    e.due  = cyc + 2;
    e.pix  = {r, g, b};
    e.sync = {fld, &fld};
    e.err  = {serr, m_sticky, 8'(m_err)};
`ifdef CL_RX_GEOMETRY_EN
    e.geo  = {16'(m_lp), 16'(m_fl), 16'(m_fc), fd};
`else
    e.geo  = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic send_r(input logic [2:0] fld);
    send(12'($urandom), 12'($urandom), 12'($urandom), fld, 3'b000, 3'b000, 1'b0);
  endtask

  task automatic line_px(input int np, input int ng);
    for (int k = 0; k < np + ng; k++)
      send_r(((k % 3 == 2) && (k / 3 < ng)) ? 3'b110 : 3'b111);
  endtask

  task automatic frame(input int nl, input int np, input int ng, input bit simul);
    repeat (2) send_r(3'b100);
    for (int l = 0; l < nl; l++) begin
      line_px(np, ng);
      if (!(simul && l == nl - 1)) repeat (2) send_r(3'b100);
    end
    repeat (3) send_r(3'b000);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    x_w = '0; y_w = '0; z_w = '0; clr = 1'b0;
    exp_q.delete();
    model_reset();
    #2;
    chk("rst_pixel", {o_r, o_g, o_b}, '0);
    chk("rst_sync", {o_f, o_l, o_d, o_v}, '0);
    chk("rst_err", {o_serr, o_sticky, o_cnt}, '0);
    chk("rst_geom", {o_lp, o_fl, o_fc, o_fd}, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.due != cyc) chk("sb_timing", 64'(cyc), 64'(e.due));
      chk("pixel", {o_r, o_g, o_b}, e.pix);
      chk("sync_valid", {o_f, o_l, o_d, o_v}, e.sync);
      chk("sync_err", {o_serr, o_sticky, o_cnt}, e.err);
      chk("geometry", {o_lp, o_fl, o_fc, o_fd}, e.geo);
    end
  end

  initial begin
    model_reset();
    do_reset();
    repeat (3) send_r(3'b000);

    // bit map: R=ABC G=123 B=456
    send(12'hABC, 12'h123, 12'h456, 3'b111, 3'b000, 3'b000, 1'b0);
    send(12'hFFF, 12'h000, 12'hFFF, 3'b111, 3'b000, 3'b000, 1'b0);
    send(12'h000, 12'hFFF, 12'h000, 3'b111, 3'b000, 3'b000, 1'b0);

    // random pixels with random sync patterns (channels agree)
    for (int i = 0; i < 40; i++) send_r(3'($urandom_range(0, 7)));
    repeat (3) send_r(3'b000);

    // 4 lines x 10 valid pixels, 2 DVAL-low cycles per line
    frame(4, 10, 2, 1'b0);
    // line 3 ends with LVAL and FVAL falling together
    frame(3, 7, 1, 1'b1);

    // three isolated Z LVAL mismatches, then clear coincident with a fourth
    for (int i = 0; i < 3; i++) begin
      send_r(3'b100);
      send(12'($urandom), 12'($urandom), 12'($urandom), 3'b100, 3'b000, 3'b010, 1'b0);
    end
    send_r(3'b100);
    send(12'($urandom), 12'($urandom), 12'($urandom), 3'b100, 3'b000, 3'b010, 1'b1);
    send_r(3'b000);
    // Y-side mismatch too
    send(12'($urandom), 12'($urandom), 12'($urandom), 3'b000, 3'b001, 3'b000, 1'b0);

    // saturation
    for (int i = 0; i < 300; i++)
      send(12'($urandom), 12'($urandom), 12'($urandom), 3'b111, 3'b000,
           3'($urandom_range(1, 7)), 1'b0);
    repeat (2) send_r(3'b000);

    // reset in the middle of a line, then a clean 2-line frame
    repeat (2) send_r(3'b100);
    line_px(10, 0);
    repeat (2) send_r(3'b100);
    repeat (4) send_r(3'b111);
    do_reset();
    repeat (2) send_r(3'b000);
    frame(2, 6, 0, 1'b0);
    repeat (3) send_r(3'b000);

    repeat (4) @(posedge clk);
    #1;
    if (exp_q.size() != 0) chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
